// File: rtl/mem_access_ctrl.sv
// Initiator side of the unified memory port: alternates FETCH/DATA phases on sclk,
// buffers one core data request, validates it and returns instruction/load data in registers.
module mem_access_ctrl #(
    parameter int DATA_LIMIT = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  fetch_addr,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        inst_err,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        sclk,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  AU_inst_sel,
    output logic        signed_inst,
    output logic [7:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic {
        DATA_PH  = 1'b0,
        FETCH_PH = 1'b1
    } phase_t;

    localparam logic [8:0] LIMIT_9 = DATA_LIMIT[8:0];

    phase_t      ph_r;
    logic        buf_full_r;
    logic        buf_write_r;
    logic [1:0]  buf_size_r;
    logic        buf_signed_r;
    logic [7:0]  buf_addr_r;
    logic [31:0] buf_wdata_r;
    logic        buf_legal_s;

    // End address is formed at 9 bits so that high addresses cannot wrap back into range.
    function automatic logic req_legal(input logic [1:0] size, input logic [7:0] addr);
        logic [8:0] nbytes;
        logic [8:0] end_addr;
        logic       ok;
        case (size)
            2'b00:   nbytes = 9'd4;
            2'b01:   nbytes = 9'd2;
            2'b10:   nbytes = 9'd1;
            default: nbytes = 9'd0;
        endcase
        end_addr = {1'b0, addr} + nbytes;
        ok       = (end_addr <= LIMIT_9);
        case (size)
            2'b00:   ok = ok && (addr[1:0] == 2'b00);
            2'b01:   ok = ok && (addr[0] == 1'b0);
            2'b10:   ok = ok;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign buf_legal_s = req_legal(buf_size_r, buf_addr_r);
    assign req_ready   = !buf_full_r;
    assign sclk        = (ph_r == FETCH_PH);

    // Phase toggle and single-entry request buffer (accept and clear never share an edge).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ph_r         <= FETCH_PH;
            buf_full_r   <= 1'b0;
            buf_write_r  <= 1'b0;
            buf_size_r   <= 2'b00;
            buf_signed_r <= 1'b0;
            buf_addr_r   <= 8'h00;
            buf_wdata_r  <= 32'h0000_0000;
        end else begin
            ph_r <= (ph_r == FETCH_PH) ? DATA_PH : FETCH_PH;
            if (req_valid && !buf_full_r) begin
                buf_full_r   <= 1'b1;
                buf_write_r  <= req_write;
                buf_size_r   <= req_size;
                buf_signed_r <= req_signed;
                buf_addr_r   <= req_addr;
                buf_wdata_r  <= req_wdata;
            end else if ((ph_r == DATA_PH) && buf_full_r) begin
                buf_full_r <= 1'b0;
            end
        end
    end

    // Registered instruction and response outputs, each valid strobe lasting one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst       <= 32'h0000_0000;
            inst_valid <= 1'b0;
            inst_err   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= 32'h0000_0000;
        end else if (ph_r == FETCH_PH) begin
            inst       <= mem_rdata;
            inst_err   <= (fetch_addr[1:0] != 2'b00);
            inst_valid <= 1'b1;
            rsp_valid  <= 1'b0;
        end else begin
            inst_valid <= 1'b0;
            if (buf_full_r) begin
                rsp_valid <= 1'b1;
                rsp_err   <= !buf_legal_s;
                rsp_rdata <= (buf_legal_s && !buf_write_r) ? mem_rdata : 32'h0000_0000;
            end else begin
                rsp_valid <= 1'b0;
            end
        end
    end

    // Memory-side decode from phase and buffer state only; rejected requests never strobe.
    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        AU_inst_sel = 2'b00;
        signed_inst = 1'b0;
        mem_addr    = 8'h00;
        mem_wdata   = 32'h0000_0000;
        if (ph_r == FETCH_PH) begin
            mem_addr = fetch_addr;
        end else if (buf_full_r && buf_legal_s) begin
            mem_addr    = buf_addr_r;
            AU_inst_sel = buf_size_r;
            signed_inst = buf_signed_r;
            mem_wdata   = buf_wdata_r;
            mem_read    = !buf_write_r;
            mem_write   = buf_write_r;
        end else begin
            mem_addr = 8'h00;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: byte-array memory model, vector table with a response scoreboard,
// plus hand-written sequences for reset, instruction fetch and mid-operation reset.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  fetch_addr;
    logic [31:0] inst;
    logic        inst_valid, inst_err;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        sclk, mem_read, mem_write, signed_inst;
    logic [1:0]  AU_inst_sel;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_access_ctrl #(.DATA_LIMIT(100)) dut (
        .clk(clk), .rst(rst), .fetch_addr(fetch_addr),
        .inst(inst), .inst_valid(inst_valid), .inst_err(inst_err),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .sclk(sclk), .mem_read(mem_read), .mem_write(mem_write),
        .AU_inst_sel(AU_inst_sel), .signed_inst(signed_inst), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Memory model: fetch uses raw address, data accesses add the +100 offset
    logic [7:0]  mem [0:255];
    logic [7:0]  snap [0:255];
    logic        init_mem;
    int          rd_base;
    logic [31:0] rd_word;
    int          wr_nb;

    always_comb begin
        rd_base = sclk ? int'(mem_addr) : int'(mem_addr) + 100;
        rd_word = {mem[(rd_base + 3) % 256], mem[(rd_base + 2) % 256],
                   mem[(rd_base + 1) % 256], mem[rd_base % 256]};
        wr_nb   = 0;
        mem_rdata = rd_word;
        if (!sclk) begin
            case (AU_inst_sel)
                2'b01: begin
                    mem_rdata = signed_inst ? {{16{rd_word[15]}}, rd_word[15:0]} : {16'h0000, rd_word[15:0]};
                    wr_nb = 2;
                end
                2'b10: begin
                    mem_rdata = signed_inst ? {{24{rd_word[7]}}, rd_word[7:0]} : {24'h000000, rd_word[7:0]};
                    wr_nb = 1;
                end
                default: wr_nb = 4;
            endcase
        end
    end

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[4]   <= 8'h83; mem[5]   <= 8'h20;
            mem[100] <= 8'h11; mem[104] <= 8'h09;
            mem[196] <= 8'h44; mem[197] <= 8'h33; mem[198] <= 8'h22; mem[199] <= 8'h11;
        end else if (mem_write) begin
            for (int k = 0; k < 4; k++)
                if (k < wr_nb) mem[(int'(mem_addr) + 100 + k) % 256] <= mem_wdata[8*k +: 8];
        end
    end

    // Strobe monitor
    int strobe_cnt = 0;
    int wr_in_fetch = 0;
    always @(negedge clk) begin
        if (mem_read || mem_write) strobe_cnt <= strobe_cnt + 1;
        if (mem_write && sclk) wr_in_fetch <= wr_in_fetch + 1;
    end

    typedef struct {
        logic        write;
        logic [1:0]  size;
        logic        sgn;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    vec_t vecs [18];
    exp_t sb_q [$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input logic want_fetch, input int idx);
        int   lat;
        int   s0;
        int   diffs;
        logic acc_fetch;
        bit   seen;
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (req_ready && (sclk == want_fetch)) break;
        end
        acc_fetch = sclk;
        s0 = strobe_cnt;
        for (int i = 0; i < 256; i++) snap[i] = mem[i];
        req_write  = v.write;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_valid  = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        sb_q.push_back(e);
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat  = k;
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL vec%0d_rsp_timeout: got no rsp_valid, expected one within 8 cycles", idx);
            void'(sb_q.pop_front());
        end else begin
            e = sb_q.pop_front();
            check($sformatf("vec%0d_rdata", idx), rsp_rdata, e.rdata);
            check($sformatf("vec%0d_err", idx), 32'(rsp_err), 32'(e.err));
            check($sformatf("vec%0d_latency", idx), 32'(lat), acc_fetch ? 32'd2 : 32'd3);
        end
        #1;
        check($sformatf("vec%0d_strobes", idx), 32'(strobe_cnt - s0), v.exp_err ? 32'd0 : 32'd1);
        if (v.exp_err) begin
            diffs = 0;
            for (int i = 0; i < 256; i++) if (mem[i] !== snap[i]) diffs++;
            check($sformatf("vec%0d_mem_unchanged", idx), 32'(diffs), 32'd0);
        end
    endtask

    initial begin
        int rsp_seen;
        vecs[0]  = '{1'b1, 2'b00, 1'b0, 8'd12,  32'hDEADBEEF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 2'b00, 1'b0, 8'd12,  32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 2'b10, 1'b1, 8'd0,   32'h0,        32'h0000_0011, 1'b0};
        vecs[3]  = '{1'b0, 2'b01, 1'b0, 8'd0,   32'h0,        32'h0000_0011, 1'b0};
        vecs[4]  = '{1'b0, 2'b00, 1'b0, 8'd4,   32'h0,        32'h0000_0009, 1'b0};
        vecs[5]  = '{1'b0, 2'b00, 1'b0, 8'd2,   32'h0,        32'h0000_0000, 1'b1};
        vecs[6]  = '{1'b1, 2'b01, 1'b0, 8'd1,   32'h0000FFFF, 32'h0000_0000, 1'b1};
        vecs[7]  = '{1'b0, 2'b00, 1'b0, 8'd96,  32'h0,        32'h1122_3344, 1'b0};
        vecs[8]  = '{1'b0, 2'b01, 1'b0, 8'd98,  32'h0,        32'h0000_1122, 1'b0};
        vecs[9]  = '{1'b0, 2'b00, 1'b0, 8'd98,  32'h0,        32'h0000_0000, 1'b1};
        vecs[10] = '{1'b1, 2'b10, 1'b0, 8'd99,  32'h0000_00A5, 32'h0000_0000, 1'b0};
        vecs[11] = '{1'b0, 2'b10, 1'b1, 8'd99,  32'h0,        32'hFFFF_FFA5, 1'b0};
        vecs[12] = '{1'b0, 2'b00, 1'b0, 8'd254, 32'h0,        32'h0000_0000, 1'b1};
        vecs[13] = '{1'b0, 2'b11, 1'b0, 8'd0,   32'h0,        32'h0000_0000, 1'b1};
        vecs[14] = '{1'b0, 2'b01, 1'b1, 8'd12,  32'h0,        32'hFFFF_BEEF, 1'b0};
        vecs[15] = '{1'b0, 2'b01, 1'b0, 8'd14,  32'h0,        32'h0000_DEAD, 1'b0};
        vecs[16] = '{1'b1, 2'b01, 1'b0, 8'd16,  32'h1234_8765, 32'h0000_0000, 1'b0};
        vecs[17] = '{1'b0, 2'b00, 1'b0, 8'd16,  32'h0,        32'h0000_8765, 1'b0};

        rst = 1'b0; init_mem = 1'b1; fetch_addr = 8'd4;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 8'd0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        init_mem = 1'b0;
        check("rst_sclk", 32'(sclk), 32'd1);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
        check("rst_inst", inst, 32'h0);
        check("rst_valids", 32'({inst_valid, inst_err, rsp_valid, rsp_err}), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);

        @(negedge clk);
        rst = 1'b1;
        #1 check("first_fetch_sclk", 32'(sclk), 32'd1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("phase%0d_sclk", k), 32'(sclk), (k % 2 == 1) ? 32'd1 : 32'd0);
            check($sformatf("phase%0d_inst_valid", k), 32'(inst_valid), (k % 2 == 0) ? 32'd1 : 32'd0);
            if (k == 0) begin
                check("fetch_inst", inst, 32'h0000_2083);
                check("fetch_inst_err", 32'(inst_err), 32'd0);
            end
        end

        for (int i = 0; i < 18; i++) run_vec(vecs[i], (i % 2 == 0), i);

        @(negedge clk);
        fetch_addr = 8'd6;
        repeat (2) @(negedge clk);
        check("misaligned_fetch_err", 32'(inst_err), 32'd1);
        fetch_addr = 8'd4;
        repeat (2) @(negedge clk);
        check("aligned_fetch_err", 32'(inst_err), 32'd0);

        // Reset between accept and the DATA edge drops the store
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (req_ready && sclk) break;
        end
        req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 8'd20; req_wdata = 32'hCAFE_F00D; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("midrst_write_strobe", 32'(mem_write), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("midrst_sclk", 32'(sclk), 32'd1);
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        check("midrst_write_off", 32'(mem_write), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        rsp_seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
        end
        check("midrst_no_rsp", 32'(rsp_seen), 32'd0);
        check("midrst_mem", {mem[123], mem[122], mem[121], mem[120]}, 32'h0);
        check("write_in_fetch", 32'(wr_in_fetch), 32'd0);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Initiator side of the unified byte-addressed memory port. It generates the `sclk` phase signal and time-multiplexes the single memory between instruction fetch (`sclk`=1) and data load/store (`sclk`=0). It accepts one core data request at a time through a valid/ready handshake, checks alignment and range, and returns fetched instructions and load data in registers. It sits between the single-cycle core and the `Memory` block.

## Interface
- `DATA_LIMIT`, 100: size in bytes of the data window (memory adds its internal +100 offset); access legal iff `req_addr + nbytes <= DATA_LIMIT`.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `fetch_addr`  in  8  instruction byte address for the next FETCH phase.
- `inst`  out  32  last fetched instruction.
- `inst_valid`  out  1  one-cycle pulse: `inst`/`inst_err` updated.
- `inst_err`  out  1  fetch address misaligned (`fetch_addr[1:0]!=0`).
- `req_valid`  in  1  core data request valid.
- `req_ready`  out  1  request buffer empty.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 word, 01 half, 10 byte, 11 illegal.
- `req_signed`  in  1  sign-extend load (half/byte).
- `req_addr`  in  8  data byte address (pre-offset).
- `req_wdata`  in  32  store data.
- `rsp_valid`  out  1  one-cycle pulse: request completed.
- `rsp_rdata`  out  32  load data; 0 for stores and errors.
- `rsp_err`  out  1  request rejected (misaligned, illegal size, out of range).
- `sclk`  out  1  memory phase: 1 FETCH, 0 DATA.
- `mem_read`, `mem_write`  out  1  memory strobes, only while `sclk`=0.
- `AU_inst_sel`  out  2  access size to memory.
- `signed_inst`  out  1  sign select to memory.
- `mem_addr`  out  8  memory address.
- `mem_wdata`  out  32  store data to memory.
- `mem_rdata`  in  32  memory read data (combinational).

## Operation
- Phase register `ph` toggles every cycle; `sclk = ph`. States: FETCH (ph=1) → DATA (ph=0) → FETCH…
- FETCH: `mem_addr=fetch_addr`, `mem_read=mem_write=0`, `AU_inst_sel=00`. At the end edge: `inst<=mem_rdata`, `inst_err<=(fetch_addr[1:0]!=0)`, `inst_valid<=1`.
- Request buffer (1 entry): `req_ready = !buf_full`. On `req_valid && req_ready` the buffer captures write/size/signed/addr/wdata; `buf_full<=1`. No accept while full.
- DATA with buffer full and legal request: drive `mem_addr`, `AU_inst_sel=size`, `signed_inst`, `mem_wdata`, `mem_read=!write`, `mem_write=write`. At the end edge: `rsp_valid<=1`, `rsp_err<=0`, `rsp_rdata<=` load ? `mem_rdata` : 0, and the buffer is cleared.
- DATA with buffer full and illegal request: strobes stay 0; at the end edge `rsp_valid<=1`, `rsp_err<=1`, `rsp_rdata<=0`, and the buffer is cleared.
- Illegal request conditions:
  - size 11;
  - word with `addr[1:0]!=0`;
  - half with `addr[0]!=0`;
  - `addr+nbytes > DATA_LIMIT`, computed at 9 bits with no wrap.
- DATA with buffer empty: strobes 0, `mem_addr=0`, `AU_inst_sel=00`.
- Memory-side outputs are combinational decodes of registered state (`ph`, buffer) and `fetch_addr` only. They never depend on `req_*` directly.
- `inst_valid` and `rsp_valid` are high for exactly one cycle per event.

## Timing
- Reset (async, `rst`=0):
  - `ph=1`, `buf_full=0`.
  - `inst`, `rsp_rdata` = 0; `inst_valid`, `inst_err`, `rsp_valid`, `rsp_err` = 0.
  - Hence `sclk=1`, `mem_read=mem_write=0`, `req_ready=1`.
- The first cycle after reset release is FETCH. `inst_valid` is high in every DATA cycle thereafter.
- Request accepted at an edge ending a FETCH cycle: serviced in the next cycle (DATA); `rsp_valid` in the following FETCH cycle. Latency 2 cycles from accept edge to `rsp_valid`.
- Request accepted at an edge ending a DATA cycle: the FETCH phase intervenes. Latency 3 cycles.
- The accept and clear edges never coincide. Maximum throughput is one request per 2 cycles.
- Buffer clear and new accept are mutually exclusive (`req_ready` is 0 while full).
- `mem_write` rises and falls on the same edges as `sclk` falls and rises; it is never 1 while `sclk`=1.
- Reset mid-operation: a pending request is dropped silently. There is no `rsp_valid` and no strobe after `rst` falls.

## Test plan
- Reset release, `fetch_addr=4`, memory holding `lw x1,0(x0)` → `inst=0x00002083`, `inst_valid` pulses every 2nd cycle, `sclk` alternates starting at 1.
- Store then load:
  - sw addr 12, wdata 0xDEADBEEF → `rsp_valid`, `rsp_err=0`, `rsp_rdata=0`.
  - lw addr 12 → `rsp_rdata=0xDEADBEEF`.
- Preloaded data (mem[100]=17, mem[104]=9):
  - lb addr 0 → `0x00000011`;
  - lhu addr 0 → `0x00000011`;
  - lw addr 4 → `0x00000009`.
- Misaligned, both with `rsp_err=1`, `rsp_rdata=0`, and `mem_read`/`mem_write` never asserted, memory unchanged:
  - lw addr 2;
  - sh addr 1.
- Range, `DATA_LIMIT=100`:
  - lw addr 96 → ok;
  - lw addr 98 → `rsp_err=1`;
  - sb addr 99 → ok;
  - lw addr 254 → `rsp_err=1` (no wrap).
- Accept a sw at an edge ending FETCH, assert `rst`=0 before the DATA edge → no `rsp_valid`, target bytes unchanged, `req_ready=1`, `sclk=1` after release.
